// File: rtl/des_key_pkg.sv
// rtl/des_key_pkg.sv - DES key schedule tables, helper functions and controller types
package des_key_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int KEY_W      = 64;
    localparam int CD_W       = 56;
    localparam int RK_W       = 48;

    // Permuted choice 1, FIPS numbering (bit 1 = MSB of the 64-bit key).
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2, FIPS numbering (bit 1 = MSB of the 56-bit CD).
    localparam int PC2_TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-shift amount for round n is SHIFT_TAB[n-1].
    localparam logic [1:0] SHIFT_TAB [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [RK_W-1:0] r;
        r = '0;
        for (int i = 0; i < RK_W; i++) begin
            r[6'(RK_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
        return r;
    endfunction

    // Only shift amounts of 1 and 2 occur in the schedule.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // C and D halves rotate independently.
    function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

endpackage

// File: rtl/des_pc2_map.sv
// rtl/des_pc2_map.sv - combinational PC2 mapping from CD state to a 48-bit round key
// Ports:
//   i_cd  56-bit C||D state, FIPS bit 1 = i_cd[55]
//   o_rk  48-bit round key,   FIPS bit 1 = o_rk[47]
module des_pc2_map
    import des_key_pkg::*;
(
    input  logic [CD_W-1:0] i_cd,
    output logic [RK_W-1:0] o_rk
);

    assign o_rk = pc2(i_cd);

endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - sequential DES key scheduler streaming 16 round keys per job
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start_valid/start_ready       job request handshake; key_in and decrypt sampled on transfer
//   key_in[63:0], decrypt         DES key incl. parity bits; 1 = emit K16..K1
//   abort                         cancel current job (also blocks a start in the same cycle)
//   rk_valid/rk_ready             round key stream handshake
//   rk_data[47:0], rk_idx[3:0]    round key and its FIPS round number minus 1
//   rk_last                       marks the 16th key of the job
//   busy                          job in progress
//   parity_err                    some key byte had even parity (only with CHECK_PARITY=1)
module des_key_sched_ctrl
    import des_key_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b0
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               decrypt,
    input  logic               abort,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [RK_W-1:0]    rk_data,
    output logic [3:0]         rk_idx,
    output logic               rk_last,
    output logic               busy,
    output logic               parity_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CD_W-1:0] r_cd;
    logic [3:0]      r_beat;
    logic            r_decrypt;
    logic            r_parity_err;

    logic            w_start_xfer;
    logic            w_advance;
    logic [CD_W-1:0] w_pc1;
    logic [1:0]      w_shift_enc;
    logic [1:0]      w_shift_dec;
    logic            w_key_parity_err;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        start_ready  = 1'b0;
        rk_valid     = 1'b0;
        busy         = 1'b0;
        w_start_xfer = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid && !abort) begin
                    w_start_xfer = 1'b1;
                    w_state_nxt  = RUN;
                end
            end
            RUN: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                // Abort wins over a handshake in the same cycle; that key is dropped.
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (rk_ready) begin
                    if (r_beat == 4'd15) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    assign w_pc1 = pc1(key_in);

    // Encrypt moves from round b+1 to b+2; decrypt undoes the shift of round 16-b.
    assign w_shift_enc = SHIFT_TAB[r_beat + 4'd1];
    assign w_shift_dec = SHIFT_TAB[4'd15 - r_beat];

    always_comb begin
        w_key_parity_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!(^key_in[8*i +: 8])) begin
                w_key_parity_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cd         <= '0;
            r_beat       <= '0;
            r_decrypt    <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (w_start_xfer) begin
            // Decrypt starts from C16D16, which equals C0D0 since the shifts total 28.
            r_cd         <= decrypt ? w_pc1 : rotl_cd(w_pc1, 2'd1);
            r_beat       <= '0;
            r_decrypt    <= decrypt;
            r_parity_err <= w_key_parity_err;
        end else if (w_advance) begin
            r_beat <= r_beat + 4'd1;
            r_cd   <= r_decrypt ? rotr_cd(r_cd, w_shift_dec) : rotl_cd(r_cd, w_shift_enc);
        end
    end

    // ---------------------------------------------------------------- outputs
    des_pc2_map u_pc2 (
        .i_cd (r_cd),
        .o_rk (rk_data)
    );

    assign rk_idx     = r_decrypt ? (4'd15 - r_beat) : r_beat;
    assign rk_last    = (r_state == RUN) && (r_beat == 4'd15);
    assign parity_err = CHECK_PARITY ? r_parity_err : 1'b0;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb/tb_des_key_sched_ctrl.sv - self-checking bench for des_key_sched_ctrl
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [63:0] key_in;
    logic        decrypt;
    logic        abort;
    logic        rk_valid;
    logic        rk_ready;
    logic [47:0] rk_data;
    logic [3:0]  rk_idx;
    logic        rk_last;
    logic        busy;
    logic        parity_err;

    des_key_sched_ctrl #(.CHECK_PARITY(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .key_in      (key_in),
        .decrypt     (decrypt),
        .abort       (abort),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_idx      (rk_idx),
        .rk_last     (rk_last),
        .busy        (busy),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [47:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        hold_start;
        logic [47:0] first_rk;
        logic [3:0]  first_idx;
        logic [47:0] last_rk;
        logic [3:0]  last_idx;
        logic        perr;
    } vec_t;

    vec_t vecs[6];

    // Reference key schedule: textbook cumulative left shifts, FIPS bit numbering.
    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int TB_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] ref_k [16];

    task automatic compute_ref(input logic [63:0] key);
        logic [1:64] kb;
        logic [1:56] cd;
        logic [1:28] c;
        logic [1:28] d;
        logic [1:48] k;
        kb = key;
        for (int i = 0; i < 56; i++) cd[i+1] = kb[TB_PC1[i]];
        c = cd[1:28];
        d = cd[29:56];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < TB_SH[r]; s++) begin
                c = {c[2:28], c[1]};
                d = {d[2:28], d[1]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[j+1] = cd[TB_PC2[j]];
            ref_k[r] = k;
        end
    endtask

    task automatic push_expect(input logic [63:0] key, input logic dec);
        exp_t e;
        int   r;
        compute_ref(key);
        for (int i = 0; i < 16; i++) begin
            r      = dec ? 15 - i : i;
            e.data = ref_k[r];
            e.idx  = 4'(r);
            e.last = (i == 15);
            sb_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [47:0] first_rk;
    logic [47:0] last_rk;
    logic [3:0]  first_idx;
    logic [3:0]  last_idx;
    logic        last_flag;
    logic        first_perr;
    int          beats;
    int          cyc;
    int          sr_high;

    // One clock cycle, entered and left at posedge+1. Pops the scoreboard on handshake.
    task automatic step(input logic rdy);
        logic [47:0] d0;
        logic [3:0]  i0;
        logic        was_stall;
        exp_t        e;
        rk_ready  = rdy;
        was_stall = rk_valid && !rdy;
        d0        = rk_data;
        i0        = rk_idx;
        if (rk_valid && start_ready) sr_high++;
        if (rk_valid && rdy) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rk_data", rk_data, e.data);
                check("rk_idx", rk_idx, e.idx);
                check("rk_last", rk_last, e.last);
            end
            if (beats == 0) begin
                first_rk   = rk_data;
                first_idx  = rk_idx;
                first_perr = parity_err;
            end
            last_rk   = rk_data;
            last_idx  = rk_idx;
            last_flag = rk_last;
            beats++;
        end
        @(posedge clk); #1;
        if (was_stall) begin
            check("stall_valid", rk_valid, 1'b1);
            check("stall_data", rk_data, d0);
            check("stall_idx", rk_idx, i0);
        end
    endtask

    task automatic begin_job(input logic [63:0] key, input logic dec, input logic hold);
        int guard;
        guard = 0;
        while (!start_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("start_ready_pre", start_ready, 1'b1);
        key_in      = key;
        decrypt     = dec;
        start_valid = 1'b1;
        push_expect(key, dec);
        @(posedge clk); #1;
        if (!hold) start_valid = 1'b0;
        beats   = 0;
        cyc     = 0;
        sr_high = 0;
        check("first_beat_latency", rk_valid, 1'b1);
    endtask

    task automatic run_job(input logic [63:0] key, input logic dec, input bit rand_rdy,
                           input logic hold);
        begin_job(key, dec, hold);
        while (beats < 16 && cyc < 2000) begin
            step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            cyc++;
        end
        start_valid = 1'b0;
        rk_ready    = 1'b0;
        if (beats < 16) check("job_timeout", 64'(beats), 64'd16);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        key_in      = '0;
        decrypt     = 1'b0;
        abort       = 1'b0;
        rk_ready    = 1'b0;

        vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 1'b0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15, 1'b0};
        vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 1'b0, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0,  1'b0};
        vecs[2] = '{64'h133457799BBCDFF0, 1'b0, 1'b1, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15, 1'b1};
        vecs[3] = '{64'h0101010101010101, 1'b1, 1'b0, 48'h000000000000, 4'd15, 48'h000000000000, 4'd0,  1'b0};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 48'hFFFFFFFFFFFF, 4'd0,  48'hFFFFFFFFFFFF, 4'd15, 1'b1};
        vecs[5] = '{64'h0000000000000000, 1'b0, 1'b0, 48'h000000000000, 4'd0,  48'h000000000000, 4'd15, 1'b1};

        // Reset state
        #2;
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_rk_valid", rk_valid, 1'b0);
        check("rst_rk_data", rk_data, 48'd0);
        check("rst_rk_idx", rk_idx, 4'd0);
        check("rst_rk_last", rk_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", rk_valid, 1'b0);

        // Known-answer table, rk_ready held high
        for (int v = 0; v < 6; v++) begin
            run_job(vecs[v].key, vecs[v].dec, 1'b0, vecs[v].hold_start);
            check("tbl_first_rk", first_rk, vecs[v].first_rk);
            check("tbl_first_idx", first_idx, vecs[v].first_idx);
            check("tbl_last_rk", last_rk, vecs[v].last_rk);
            check("tbl_last_idx", last_idx, vecs[v].last_idx);
            check("tbl_last_flag", last_flag, 1'b1);
            check("tbl_parity_err", first_perr, vecs[v].perr);
            check("tbl_cycles", 64'(cyc), 64'd16);
            check("tbl_no_start_ready_in_run", 64'(sr_high), 64'd0);
            check("tbl_end_start_ready", start_ready, 1'b1);
            check("tbl_end_rk_valid", rk_valid, 1'b0);
            check("tbl_end_busy", busy, 1'b0);
        end

        // Random keys, both modes, random backpressure
        for (int n = 0; n < 200; n++) begin
            for (int m = 0; m < 2; m++) begin
                run_job({$urandom, $urandom}, 1'(m), 1'b1, 1'b0);
            end
        end
        check("sb_empty_after_random", 64'(sb_q.size()), 64'd0);

        // Abort at beat 7 together with a handshake
        begin_job(64'h133457799BBCDFF1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1);
        check("abort_pre_idx", rk_idx, 4'd7);
        abort    = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        rk_ready = 1'b0;
        check("abort_rk_valid", rk_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_start_ready", start_ready, 1'b1);
        sb_q.delete();
        run_job(64'h0000000000000000, 1'b0, 1'b0, 1'b0);
        check("after_abort_k1", first_rk, 48'h000000000000);
        check("after_abort_beats", 64'(beats), 64'd16);

        // Abort in IDLE blocks a simultaneous start
        start_valid = 1'b1;
        key_in      = 64'h133457799BBCDFF1;
        abort       = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        abort       = 1'b0;
        check("idle_abort_busy", busy, 1'b0);
        check("idle_abort_rk_valid", rk_valid, 1'b0);

        // Asynchronous reset mid-job at beat 4
        begin_job(64'h0E329232EA6D0D73, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_start_ready", start_ready, 1'b1);
        check("arst_rk_valid", rk_valid, 1'b0);
        check("arst_rk_data", rk_data, 48'd0);
        check("arst_rk_idx", rk_idx, 4'd0);
        check("arst_rk_last", rk_last, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_parity_err", parity_err, 1'b0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("arst_no_valid", rk_valid, 1'b0);
        end
        run_job(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0);
        check("arst_recover_k1", first_rk, 48'h1B02EFFC7072);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
Sequential DES key scheduler. It accepts one 64-bit key per job and streams the 16 round keys, one per cycle, over a valid/ready interface. It replaces the fully unrolled 16-stage key generator wherever area matters, and sits beside an iterative round engine that consumes one subkey per round. Encrypt order is K1..K16; decrypt order is K16..K1, produced by right rotations without precomputation.

Parameters:
CHECK_PARITY, 0, 1 = check odd parity on each key byte at start acceptance and report the result on parity_err.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  job request
start_ready  out  1  block can accept a job
key_in  in  64  DES key incl. parity bits; FIPS bit 1 = key_in[63]
decrypt  in  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with key_in
abort  in  1  synchronous cancel of the current job
rk_valid  out  1  rk_data valid
rk_ready  in  1  consumer accepts rk_data
rk_data  out  48  current round key; FIPS bit 1 = rk_data[47]
rk_idx  out  4  FIPS round number minus 1 of rk_data (K1 = 0)
rk_last  out  1  high with the 16th key of the job
busy  out  1  job in progress
parity_err  out  1  sticky per job; set at acceptance if any byte has even parity; cleared at next acceptance

Behaviour:
- Reset values: start_ready=1, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, busy=0, parity_err=0. CD register and beat counter reset to 0.
- State register: 56-bit CD (C = [55:28], D = [27:0]). rk_data = PC2(CD), pure wiring from the register, so it is stable while rk_valid=1.
- SHIFT[n], n=1..16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- FSM IDLE:
  - start_ready=1, rk_valid=0.
  - Transfer occurs on start_valid & start_ready.
  - On transfer: encrypt loads CD <= rotl(PC1(key_in), 1); decrypt loads CD <= PC1(key_in).
  - Also on transfer: beat counter b <= 0, latch mode, go to RUN.
- FSM RUN:
  - start_ready=0, busy=1, rk_valid=1.
  - rk_idx = b when encrypt, 15-b when decrypt. rk_last = (b==15).
  - Handshake occurs on rk_valid & rk_ready.
  - On handshake with b<15: b++. Encrypt: CD <= rotl(CD, SHIFT[b+2]). Decrypt: CD <= rotr(CD, SHIFT[16-b]). Rotations apply to C and D independently.
  - On handshake with b==15: go to IDLE.
  - rk_ready=0 holds all state; rk_valid stays high (no retraction).
- Latency: first key is valid the cycle after start acceptance. Sustained rate is 1 key/cycle with rk_ready held high, so a job takes 16 cycles. IDLE lasts at least 1 cycle between jobs (start_ready rises the cycle after the last handshake).
- Abort: in RUN, go to IDLE next cycle with rk_valid=0, and any handshake in that same cycle is discarded. Abort has priority over a simultaneous handshake, and over a start transfer in IDLE.
- start_valid while busy is ignored; start_ready=0 stalls the requester.
- rst_n low at any time: immediate return to reset values. A partially emitted job is lost, and the consumer must drop it.
- parity_err: with CHECK_PARITY=0 it is tied to 0. Parity is informational only; the job runs regardless.
- rk_data in IDLE holds the last CD mapping; consumers qualify it with rk_valid.

Decomposition:
- Package des_key_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries), FIPS numbering.
  - SHIFT schedule array.
  - Functions pc1(), pc2(), rotl28(), rotr28().
  - Localparams NUM_ROUNDS=16, KEY_W=64, CD_W=56, RK_W=48.
  - FSM state enum {IDLE, RUN}.
- One sub-module, des_pc2_map: combinational PC2 wiring. It is shared with the iterative round engine's bench model.

Test Plan:
- Encrypt, key 133457799BBCDFF1, rk_ready=1 → K1=1B02EFFC7072 one cycle after start; K16=CB3D8B0E17F5 on the 16th beat with rk_idx=15 and rk_last=1; 16 consecutive valid cycles; start_ready returns high on the cycle after.
- Decrypt, same key → first beat rk_idx=15, rk_data=CB3D8B0E17F5; last beat rk_idx=0, rk_data=1B02EFFC7072, rk_last=1; full sequence equals the encrypt sequence reversed.
- Random rk_ready backpressure (≈50% duty), 200 random keys × both modes → every accepted key matches a reference model; rk_data and rk_idx are stable while rk_valid & !rk_ready.
- abort asserted on beat 7 together with rk_ready=1 → rk_valid=0 next cycle, busy=0, start_ready=1; the next job with key 0000000000000000 gives K1=000000000000.
- rst_n pulsed low mid-job (beat 4), asynchronous to clk → all outputs at reset values immediately; no rk_valid until a new start.
- CHECK_PARITY=1, key 133457799BBCDFF1 → parity_err=0; key 133457799BBCDFF0 → parity_err=1 from the cycle after acceptance, and round keys are still emitted correctly; start_valid held high during RUN is not accepted.
